// File: rtl/voice_display_sequencer.sv
// Voice-command sequencer: records spoken numbers (1-99) into a small buffer and
// plays them back round-robin on a two-digit BCD display, each held for HOLD_CYCLES.
module voice_display_sequencer #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HOLD_CYCLES = 100000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               id_data,
  input  logic                     id_valid,
  output logic [3:0]               disp_tens,
  output logic [3:0]               disp_units,
  output logic                     blank,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HoldLast = HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRecord = 2'd1,
    StPlay   = 2'd2
  } state_e;

  state_e          r_state, w_state_d;
  logic [CW-1:0]   r_count, w_count_d;
  logic [AW-1:0]   r_rd_ptr, w_rd_ptr_d;
  logic [HW-1:0]   r_hold, w_hold_d;
  logic            r_overflow, w_overflow_d;
  logic            r_blank, w_blank_d;
  logic [3:0]      r_tens, w_tens_d;
  logic [3:0]      r_units, w_units_d;
  logic [6:0]      r_buf [DEPTH];
  logic            w_wr_en;
  logic            w_id_ok;
  logic [6:0]      w_val;

  assign w_id_ok = id_valid && (id_data <= 8'd99);

  always_comb begin
    w_state_d    = r_state;
    w_count_d    = r_count;
    w_rd_ptr_d   = r_rd_ptr;
    w_hold_d     = r_hold;
    w_overflow_d = r_overflow;
    w_wr_en      = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_id_ok && id_data == 8'd5) begin
          w_state_d    = StRecord;
          w_count_d    = '0;
          w_overflow_d = 1'b0;
        end
      end
      StRecord: begin
        if (w_id_ok) begin
          if (id_data == 8'd0) begin
            w_state_d    = StIdle;
            w_count_d    = '0;
            w_overflow_d = 1'b0;
          end else if (id_data == 8'd5 || id_data == 8'd47) begin
            w_count_d    = '0;
            w_overflow_d = 1'b0;
          end else if (id_data == 8'd46) begin
            if (r_count != '0) begin
              w_state_d  = StPlay;
              w_rd_ptr_d = '0;
              w_hold_d   = '0;
            end else begin
              w_state_d  = StIdle;
            end
          end else if (r_count < CountFull) begin
            w_wr_en   = 1'b1;
            w_count_d = r_count + CW'(1);
          end else begin
            w_overflow_d = 1'b1;
          end
        end
      end
      StPlay: begin
        if (r_hold == HoldLast) begin
          w_hold_d   = '0;
          w_rd_ptr_d = ({1'b0, r_rd_ptr} == r_count - CW'(1)) ? '0 : r_rd_ptr + AW'(1);
        end else begin
          w_hold_d = r_hold + HW'(1);
        end
        if (w_id_ok && (id_data == 8'd5 || id_data == 8'd47)) begin
          w_state_d    = StRecord;
          w_count_d    = '0;
          w_overflow_d = 1'b0;
        end else if (w_id_ok && id_data == 8'd0) begin
          w_state_d    = StIdle;
          w_count_d    = '0;
          w_overflow_d = 1'b0;
        end
      end
      default: begin
        w_state_d    = StIdle;
        w_count_d    = '0;
        w_overflow_d = 1'b0;
      end
    endcase
  end

  // Digits are looked up with the next read pointer so entry 0 appears on the first PLAY cycle.
  assign w_val = r_buf[w_rd_ptr_d];

  always_comb begin
    w_blank_d = (w_state_d != StPlay);
    w_tens_d  = '0;
    w_units_d = '0;
    if (w_state_d == StPlay) begin
      w_tens_d  = 4'(w_val / 7'd10);
      w_units_d = 4'(w_val % 7'd10);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_hold     <= '0;
      r_overflow <= 1'b0;
      r_blank    <= 1'b1;
      r_tens     <= '0;
      r_units    <= '0;
    end else begin
      r_state    <= w_state_d;
      r_count    <= w_count_d;
      r_rd_ptr   <= w_rd_ptr_d;
      r_hold     <= w_hold_d;
      r_overflow <= w_overflow_d;
      r_blank    <= w_blank_d;
      r_tens     <= w_tens_d;
      r_units    <= w_units_d;
    end
  end

  // Buffer storage needs no reset: entries at or beyond count are never displayed.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_buf[r_count[AW-1:0]] <= id_data[6:0];
    end
  end

  assign disp_tens  = r_tens;
  assign disp_units = r_units;
  assign blank      = r_blank;
  assign state      = r_state;
  assign count      = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_voice_display_sequencer.sv
// Self-checking bench: a queue-based behavioural model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_voice_display_sequencer;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] id_data = 8'd0;
  logic       id_valid = 1'b0;
  logic [3:0] disp_tens, disp_units;
  logic       blank;
  logic [1:0] state;
  logic [2:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  voice_display_sequencer #(
    .DEPTH      (DEPTH),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .id_data   (id_data),
    .id_valid  (id_valid),
    .disp_tens (disp_tens),
    .disp_units(disp_units),
    .blank     (blank),
    .state     (state),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Model: mode number, list of stored numbers, and the cycle playback started.
  int m_st = 0;
  int q[$];
  int m_ovf = 0;
  int m_cyc = 0;
  int m_start = 0;
  int m_id;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st = 0;
      q.delete();
      m_ovf = 0;
    end else begin
      m_cyc++;
      m_id = int'(id_data);
      if (id_valid && m_id <= 99) begin
        if (m_st == 0) begin
          if (m_id == 5) begin m_st = 1; q.delete(); m_ovf = 0; end
        end else if (m_st == 1) begin
          if (m_id == 0) begin m_st = 0; q.delete(); m_ovf = 0; end
          else if (m_id == 5 || m_id == 47) begin q.delete(); m_ovf = 0; end
          else if (m_id == 46) begin
            if (q.size() > 0) begin m_st = 2; m_start = m_cyc; end
            else m_st = 0;
          end else if (q.size() < DEPTH) q.push_back(m_id);
          else m_ovf = 1;
        end else begin
          if (m_id == 5 || m_id == 47) begin m_st = 1; q.delete(); m_ovf = 0; end
          else if (m_id == 0) begin m_st = 0; q.delete(); m_ovf = 0; end
        end
      end
    end
  end

  int e_t, e_u, e_bl, e_v;
  always @(negedge clk) begin
    if (run_cmp) begin
      e_bl = (m_st == 2) ? 0 : 1;
      e_t = 0;
      e_u = 0;
      if (m_st == 2) begin
        e_v = q[((m_cyc - m_start) / HOLD) % q.size()];
        e_t = e_v / 10;
        e_u = e_v % 10;
      end
      checks++;
      if (int'(state) != m_st || int'(count) != q.size() || int'(overflow) != m_ovf ||
          int'(blank) != e_bl || int'(disp_tens) != e_t || int'(disp_units) != e_u) begin
        errors++;
        $display("FAIL model t=%0t got st=%0d cnt=%0d ovf=%0d bl=%0d d=%0d/%0d want st=%0d cnt=%0d ovf=%0d bl=%0d d=%0d/%0d",
                 $time, state, count, overflow, blank, disp_tens, disp_units,
                 m_st, q.size(), m_ovf, e_bl, e_t, e_u);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, exp);
    end
  endtask

  task automatic send(input int id);
    @(negedge clk);
    id_data  = 8'(id);
    id_valid = 1'b1;
    @(posedge clk);
    #1;
    id_valid = 1'b0;
  endtask

  task automatic check_disp(input int t, input int u, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("blank_play", int'(blank), 0);
      chk("disp_tens", int'(disp_tens), t);
      chk("disp_units", int'(disp_units), u);
    end
  endtask

  task automatic check_status(input int st, input int cnt, input int ovf, input int bl);
    @(negedge clk);
    chk("state", int'(state), st);
    chk("count", int'(count), cnt);
    chk("overflow", int'(overflow), ovf);
    chk("blank", int'(blank), bl);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_blank", int'(blank), 1);
    chk("rst_count", int'(count), 0);
    reset = 1'b0;
    run_cmp = 1'b1;

    // 1: record 13,35,44 and play with wrap
    send(5); send(13); send(35); send(44); send(46);
    check_disp(1, 3, 4); check_disp(3, 5, 4); check_disp(4, 4, 4); check_disp(1, 3, 1);
    chk("t1_state", int'(state), 2);
    chk("t1_count", int'(count), 3);

    // 2: re-record from PLAY
    send(47);
    check_status(1, 0, 0, 1);
    send(30); send(38); send(46);
    check_disp(3, 0, 4); check_disp(3, 8, 4); check_disp(3, 0, 4);
    send(0);
    check_status(0, 0, 0, 1);

    // 3: overflow
    send(5); send(10); send(11); send(12); send(13); send(14);
    check_status(1, 4, 1, 1);
    send(46);
    check_disp(1, 0, 4); check_disp(1, 1, 4); check_disp(1, 2, 4); check_disp(1, 3, 4);
    check_disp(1, 0, 2);
    send(47);
    check_status(1, 0, 0, 1);
    send(0);

    // 4: IDLE ignores everything but 5; empty / out-of-range handling
    send(13); send(46); send(47); send(200);
    check_status(0, 0, 0, 1);
    send(5); send(46);
    check_status(0, 0, 0, 1);
    send(5); send(150); send(46);
    check_status(0, 0, 0, 1);

    // 5: single entry held indefinitely; numeric and 46 ignored in PLAY
    send(5); send(7); send(46);
    check_disp(0, 7, 12);
    send(99); send(46);
    check_disp(0, 7, 6);
    check_status(2, 1, 0, 0);

    // 6: asynchronous reset mid-PLAY
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_blank", int'(blank), 1);
    chk("arst_count", int'(count), 0);
    chk("arst_tens", int'(disp_tens), 0);
    chk("arst_units", int'(disp_units), 0);
    @(negedge clk);
    reset = 1'b0;
    send(46);
    check_status(0, 0, 0, 1);
    send(5); send(42); send(46);
    check_disp(4, 2, 6);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
